// File: rtl/pspin_cmd_arbiter.sv
// Command/completion arbiter between PsPIN clusters and SoC command interfaces.
// Round-robin command steering by intf_id, per-cluster credits, completion return.
package pspin_cmd_pkg;

  typedef struct packed {
    logic [7:0] cluster_id;
    logic [3:0] core_id;
    logic [3:0] local_id;
  } pspin_cmd_id_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [1:0]    intf_id;
    logic [31:0]   descr;
  } pspin_cmd_t;

  typedef struct packed {
    pspin_cmd_id_t cmd_id;
    logic [31:0]   status;
  } pspin_cmd_resp_t;

endpackage

module pspin_cmd_arbiter
  import pspin_cmd_pkg::*;
#(
  parameter int NUM_CLUSTERS       = 4,
  parameter int NUM_CMD_INTERFACES = 3,
  parameter int MAX_OUTSTANDING    = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_CLUSTERS-1:0]       cluster_cmd_valid_i,
  output logic [NUM_CLUSTERS-1:0]       cluster_cmd_ready_o,
  input  pspin_cmd_t                    cluster_cmd_i [NUM_CLUSTERS],
  output logic [NUM_CMD_INTERFACES-1:0] intf_cmd_valid_o,
  input  logic [NUM_CMD_INTERFACES-1:0] intf_cmd_ready_i,
  output pspin_cmd_t                    intf_cmd_o,
  input  logic [NUM_CMD_INTERFACES-1:0] intf_resp_valid_i,
  output logic [NUM_CMD_INTERFACES-1:0] intf_resp_ready_o,
  input  pspin_cmd_resp_t               intf_resp_i [NUM_CMD_INTERFACES],
  output logic [NUM_CLUSTERS-1:0]       cluster_resp_valid_o,
  output pspin_cmd_resp_t               cluster_resp_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int CW = $clog2(NUM_CLUSTERS);
  localparam int IW = $clog2(NUM_CMD_INTERFACES);
  localparam int NW = $clog2(MAX_OUTSTANDING + 1);

  pspin_cmd_t      cmd_q;
  logic            cmd_valid_q;
  logic [CW-1:0]   cmd_ptr_q;
  logic [IW-1:0]   resp_ptr_q;
  logic [NW-1:0]   credit_q [NUM_CLUSTERS];

  logic [NUM_CLUSTERS-1:0] cmd_elig;
  logic [NUM_CLUSTERS-1:0] cmd_inc;
  logic [NUM_CLUSTERS-1:0] cmd_dec;
  logic [NUM_CLUSTERS-1:0] cred_zero;
  logic [NUM_CLUSTERS-1:0] resp_valid_d;
  logic                    cmd_found;
  logic [CW-1:0]           cmd_idx;
  logic                    cmd_drain;
  logic                    cmd_grant;
  logic                    cmd_bad;
  pspin_cmd_t              cmd_sel;
  logic                    resp_found;
  logic [IW-1:0]           resp_idx;
  pspin_cmd_resp_t         resp_sel;
  logic                    resp_bad;
  logic                    underflow;
  int                      cj;
  int                      rj;

  always_comb begin
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      cmd_elig[i]  = cluster_cmd_valid_i[i] &&
                     (credit_q[i] < NW'(MAX_OUTSTANDING));
      cred_zero[i] = (credit_q[i] == '0);
    end
  end

  // Rotating priority: first eligible cluster at or after cmd_ptr_q wins.
  always_comb begin
    cmd_found = 1'b0;
    cmd_idx   = '0;
    cj        = 0;
    for (int k = 0; k < NUM_CLUSTERS; k++) begin
      cj = int'(cmd_ptr_q) + k;
      if (cj >= NUM_CLUSTERS) cj = cj - NUM_CLUSTERS;
      if (!cmd_found && cmd_elig[cj]) begin
        cmd_found = 1'b1;
        cmd_idx   = CW'(cj);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CMD_INTERFACES; i++) begin
      intf_cmd_valid_o[i] = cmd_valid_q && (int'(cmd_q.intf_id) == i);
    end
  end

  assign intf_cmd_o = cmd_q;
  assign cmd_drain  = |(intf_cmd_valid_o & intf_cmd_ready_i);
  assign cmd_grant  = cmd_found && (!cmd_valid_q || cmd_drain);
  assign cmd_sel    = cluster_cmd_i[cmd_idx];
  assign cmd_bad    = int'(cmd_sel.intf_id) >= NUM_CMD_INTERFACES;

  always_comb begin
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      cluster_cmd_ready_o[i] = cmd_grant && (cmd_idx == CW'(i));
      cmd_inc[i]             = cluster_cmd_ready_o[i] && !cmd_bad;
      cmd_dec[i]             = cluster_resp_valid_o[i];
    end
  end

  always_comb begin
    resp_found = 1'b0;
    resp_idx   = '0;
    rj         = 0;
    for (int k = 0; k < NUM_CMD_INTERFACES; k++) begin
      rj = int'(resp_ptr_q) + k;
      if (rj >= NUM_CMD_INTERFACES) rj = rj - NUM_CMD_INTERFACES;
      if (!resp_found && intf_resp_valid_i[rj]) begin
        resp_found = 1'b1;
        resp_idx   = IW'(rj);
      end
    end
  end

  assign resp_sel = intf_resp_i[resp_idx];
  assign resp_bad = int'(resp_sel.cmd_id.cluster_id) >= NUM_CLUSTERS;

  always_comb begin
    for (int i = 0; i < NUM_CMD_INTERFACES; i++) begin
      intf_resp_ready_o[i] = resp_found && (resp_idx == IW'(i));
    end
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      resp_valid_d[i] = resp_found && !resp_bad &&
                        (int'(resp_sel.cmd_id.cluster_id) == i);
    end
  end

  assign underflow = |(cmd_dec & cred_zero);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_ptr_q   <= '0;
    end else begin
      if (cmd_grant && !cmd_bad) begin
        cmd_q       <= cmd_sel;
        cmd_valid_q <= 1'b1;
      end else if (cmd_drain) begin
        cmd_valid_q <= 1'b0;
      end
      if (cmd_grant) begin
        cmd_ptr_q <= (cmd_idx == CW'(NUM_CLUSTERS - 1)) ?
                     '0 : cmd_idx + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cluster_resp_o       <= '0;
      cluster_resp_valid_o <= '0;
      resp_ptr_q           <= '0;
    end else begin
      cluster_resp_valid_o <= resp_valid_d;
      if (resp_found) begin
        cluster_resp_o <= resp_sel;
        resp_ptr_q     <= (resp_idx == IW'(NUM_CMD_INTERFACES - 1)) ?
                          '0 : resp_idx + IW'(1);
      end
    end
  end

  // Delivery-cycle decrement: a freed credit is visible the cycle after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CLUSTERS; i++) credit_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        if (cmd_inc[i] && !cmd_dec[i]) begin
          credit_q[i] <= credit_q[i] + NW'(1);
        end else if (cmd_dec[i] && !cmd_inc[i] && !cred_zero[i]) begin
          credit_q[i] <= credit_q[i] - NW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if ((cmd_grant && cmd_bad) ||
                 (resp_found && resp_bad) || underflow) begin
      err_o <= 1'b1;
    end
  end

  always_comb begin
    busy_o = cmd_valid_q || (|cluster_resp_valid_o);
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      busy_o = busy_o || !cred_zero[i];
    end
  end

endmodule

// File: tb/tb_pspin_cmd_arbiter.sv
// Directed bench for pspin_cmd_arbiter.
// Linear stimulus with immediate-assertion checks.
module tb_pspin_cmd_arbiter;
  import pspin_cmd_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      cmd_valid;
  logic [3:0]      cmd_ready;
  pspin_cmd_t      cluster_cmd [4];
  logic [2:0]      icmd_valid;
  logic [2:0]      icmd_ready;
  pspin_cmd_t      icmd;
  logic [2:0]      iresp_valid;
  logic [2:0]      iresp_ready;
  pspin_cmd_resp_t iresp [3];
  logic [3:0]      cresp_valid;
  pspin_cmd_resp_t cresp;
  logic            busy;
  logic            err;

  int n_checks = 0;
  int n_fail   = 0;

  pspin_cmd_t      c;
  pspin_cmd_resp_t r;
  int              exp_i;
  int              prev;

  always #5 clk = ~clk;

  pspin_cmd_arbiter dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cluster_cmd_valid_i (cmd_valid),
    .cluster_cmd_ready_o (cmd_ready),
    .cluster_cmd_i       (cluster_cmd),
    .intf_cmd_valid_o    (icmd_valid),
    .intf_cmd_ready_i    (icmd_ready),
    .intf_cmd_o          (icmd),
    .intf_resp_valid_i   (iresp_valid),
    .intf_resp_ready_o   (iresp_ready),
    .intf_resp_i         (iresp),
    .cluster_resp_valid_o(cresp_valid),
    .cluster_resp_o      (cresp),
    .busy_o              (busy),
    .err_o               (err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pspin_cmd_t mk_cmd(input int cid, input int core,
                                        input int loc, input int intf,
                                        input logic [31:0] d);
    pspin_cmd_t m;
    m.cmd_id.cluster_id = 8'(cid);
    m.cmd_id.core_id    = 4'(core);
    m.cmd_id.local_id   = 4'(loc);
    m.intf_id           = 2'(intf);
    m.descr             = d;
    return m;
  endfunction

  function automatic pspin_cmd_resp_t mk_resp(input int cid,
                                              input logic [31:0] s);
    pspin_cmd_resp_t m;
    m.cmd_id.cluster_id = 8'(cid);
    m.cmd_id.core_id    = 4'd0;
    m.cmd_id.local_id   = 4'd0;
    m.status            = s;
    return m;
  endfunction

  task automatic clr();
    cmd_valid   = '0;
    icmd_ready  = 3'b111;
    iresp_valid = '0;
    for (int i = 0; i < 4; i++) cluster_cmd[i] = '0;
    for (int i = 0; i < 3; i++) iresp[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    #2;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr();
    #3;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_icmd_valid", 64'(icmd_valid), 64'(0));
    chk("rst_icmd", 64'(icmd), 64'(0));
    chk("rst_cresp_valid", 64'(cresp_valid), 64'(0));
    chk("rst_cresp", 64'(cresp), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    tick();
    rst_n = 1'b1;
    #1;

    // single command, cluster 2 -> intf 1, then its completion
    c = mk_cmd(2, 5, 3, 1, 32'hCAFE0001);
    cluster_cmd[2] = c;
    cmd_valid = 4'b0100;
    #1;
    chk("t1_ready", 64'(cmd_ready), 64'(4'b0100));
    tick();
    cmd_valid = '0;
    #1;
    chk("t1_icmd_valid", 64'(icmd_valid), 64'(3'b010));
    chk("t1_payload", 64'(icmd), 64'(c));
    chk("t1_busy", 64'(busy), 64'(1));
    tick();
    chk("t1_drained", 64'(icmd_valid), 64'(0));
    chk("t1_busy_credit", 64'(busy), 64'(1));
    r = mk_resp(2, 32'h5);
    r.cmd_id = c.cmd_id;
    iresp[1] = r;
    iresp_valid = 3'b010;
    #1;
    chk("t1_resp_ready", 64'(iresp_ready), 64'(3'b010));
    tick();
    iresp_valid = '0;
    #1;
    chk("t1_cresp_valid", 64'(cresp_valid), 64'(4'b0100));
    chk("t1_cresp", 64'(cresp), 64'(r));
    tick();
    chk("t1_cresp_once", 64'(cresp_valid), 64'(0));
    chk("t1_busy_fall", 64'(busy), 64'(0));
    chk("t1_err", 64'(err), 64'(0));

    // fairness: cmd pointer is 3 after granting cluster 2
    for (int i = 0; i < 4; i++)
      cluster_cmd[i] = mk_cmd(i, 0, 0, 0, 32'hF000 + i);
    cmd_valid = 4'b1111;
    #1;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      exp_i = (3 + k) % 4;
      chk("t2_grant", 64'(cmd_ready), 64'(1) << exp_i);
      if (k > 0) begin
        chk("t2_data", 64'(icmd.descr), 64'(32'hF000 + prev));
        chk("t2_valid", 64'(icmd_valid), 64'(3'b001));
      end
      tick();
      prev = exp_i;
    end
    cmd_valid = '0;
    #1;
    chk("t2_last", 64'(icmd.descr), 64'(32'hF000));
    tick();

    // backpressure on intf 2; pointer now at 1
    icmd_ready = 3'b011;
    c = mk_cmd(1, 1, 1, 2, 32'hAAAA);
    cluster_cmd[1] = c;
    cluster_cmd[3] = mk_cmd(3, 3, 3, 0, 32'hBBBB);
    cmd_valid = 4'b1010;
    #1;
    chk("t3_grant", 64'(cmd_ready), 64'(4'b0010));
    tick();
    cmd_valid = 4'b1000;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 64'(icmd_valid), 64'(3'b100));
      chk("t3_hold_data", 64'(icmd), 64'(c));
      chk("t3_no_ready", 64'(cmd_ready), 64'(0));
      tick();
    end
    icmd_ready = 3'b111;
    #1;
    chk("t3_same_cycle", 64'(cmd_ready), 64'(4'b1000));
    tick();
    cmd_valid = '0;
    #1;
    chk("t3_next_valid", 64'(icmd_valid), 64'(3'b001));
    chk("t3_next_data", 64'(icmd.descr), 64'(32'hBBBB));
    tick();

    // reset while cmd_q is full and credits are outstanding
    icmd_ready = 3'b110;
    cluster_cmd[0] = mk_cmd(0, 0, 0, 0, 32'hDDDD);
    cmd_valid = 4'b0001;
    #1;
    chk("t4_grant", 64'(cmd_ready), 64'(4'b0001));
    tick();
    cmd_valid = '0;
    #1;
    chk("t4_full", 64'(icmd_valid), 64'(3'b001));
    rst_n = 1'b0;
    #1;
    chk("t4_icmd_valid", 64'(icmd_valid), 64'(0));
    chk("t4_icmd", 64'(icmd), 64'(0));
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_err", 64'(err), 64'(0));
    chk("t4_cresp_valid", 64'(cresp_valid), 64'(0));
    clr();
    tick();
    rst_n = 1'b1;
    #1;
    chk("t4_credits_zero", 64'(busy), 64'(0));
    for (int i = 0; i < 4; i++)
      cluster_cmd[i] = mk_cmd(i, 0, 0, 0, 32'h1);
    cmd_valid = 4'b1111;
    #1;
    chk("t4_cmd_ptr", 64'(cmd_ready), 64'(4'b0001));
    cmd_valid = '0;
    iresp_valid = 3'b110;
    #1;
    chk("t4_resp_ptr", 64'(iresp_ready), 64'(3'b010));
    iresp_valid = '0;
    tick();

    // credit limit on cluster 0
    cluster_cmd[0] = mk_cmd(0, 0, 0, 0, 32'hEEEE);
    cmd_valid = 4'b0001;
    #1;
    for (int k = 0; k < 32; k++) begin
      chk("t5_grant", 64'(cmd_ready), 64'(4'b0001));
      tick();
    end
    chk("t5_hold", 64'(cmd_ready), 64'(0));
    tick();
    chk("t5_hold2", 64'(cmd_ready), 64'(0));
    iresp[0] = mk_resp(0, 32'h1);
    iresp_valid = 3'b001;
    #1;
    chk("t5_resp_ready", 64'(iresp_ready), 64'(3'b001));
    tick();
    iresp_valid = '0;
    #1;
    chk("t5_deliver", 64'(cresp_valid), 64'(4'b0001));
    chk("t5_still_held", 64'(cmd_ready), 64'(0));
    tick();
    chk("t5_release", 64'(cmd_ready), 64'(4'b0001));
    tick();
    cmd_valid = '0;
    #1;
    chk("t5_33rd", 64'(icmd_valid), 64'(3'b001));
    chk("t5_err", 64'(err), 64'(0));

    // bad intf_id: dropped, error, no credit
    do_reset();
    chk("t6_err_clr", 64'(err), 64'(0));
    cluster_cmd[1] = mk_cmd(1, 0, 0, 3, 32'h3333);
    cmd_valid = 4'b0010;
    #1;
    chk("t6_bad_grant", 64'(cmd_ready), 64'(4'b0010));
    tick();
    cmd_valid = '0;
    #1;
    chk("t6_dropped", 64'(icmd_valid), 64'(0));
    chk("t6_err", 64'(err), 64'(1));
    tick();
    chk("t6_no_credit", 64'(busy), 64'(0));
    chk("t6_sticky", 64'(err), 64'(1));

    // completion to a cluster holding no credit
    do_reset();
    r = mk_resp(3, 32'h77);
    iresp[2] = r;
    iresp_valid = 3'b100;
    #1;
    chk("t6u_ready", 64'(iresp_ready), 64'(3'b100));
    tick();
    iresp_valid = '0;
    #1;
    chk("t6u_deliver", 64'(cresp_valid), 64'(4'b1000));
    chk("t6u_payload", 64'(cresp), 64'(r));
    tick();
    chk("t6u_err", 64'(err), 64'(1));
    chk("t6u_no_underflow", 64'(busy), 64'(0));

    // completion with out-of-range cluster_id
    do_reset();
    iresp[0] = mk_resp(7, 32'h9);
    iresp_valid = 3'b001;
    #1;
    tick();
    iresp_valid = '0;
    #1;
    chk("t6c_dropped", 64'(cresp_valid), 64'(0));
    tick();
    chk("t6c_err", 64'(err), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pspin_cmd_arbiter.md
Name: pspin_cmd_arbiter

Overview:
- Shares the NUM_CMD_INTERFACES command interfaces (host-direct, NIC outbound, eDMA) among the NUM_CLUSTERS cluster command ports.
- Round-robin arbitrates cluster commands and steers each one to the interface selected by its intf_id.
- Enforces a per-cluster outstanding-command credit limit.
- Arbitrates interface completions and returns each one to the issuing cluster, selected by cmd_id.cluster_id.
- Sits between the cluster-side command units and the SoC-level command consumers.

Parameters:
- NUM_CLUSTERS, 4: number of requesting clusters.
- NUM_CMD_INTERFACES, 3: number of command interfaces; index equals intf_id.
- MAX_OUTSTANDING, 32 (NUM_CORES*NUM_HPU_CMDS): credit limit per cluster.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- cluster_cmd_valid_i  in  NUM_CLUSTERS  per-cluster command valid.
- cluster_cmd_ready_o  out  NUM_CLUSTERS  per-cluster command ready.
- cluster_cmd_i  in  NUM_CLUSTERS x pspin_cmd_t  cluster commands.
- intf_cmd_valid_o  out  NUM_CMD_INTERFACES  per-interface command valid.
- intf_cmd_ready_i  in  NUM_CMD_INTERFACES  per-interface command ready.
- intf_cmd_o  out  pspin_cmd_t  command bus, shared by all interfaces.
- intf_resp_valid_i  in  NUM_CMD_INTERFACES  completion valid.
- intf_resp_ready_o  out  NUM_CMD_INTERFACES  completion ready.
- intf_resp_i  in  NUM_CMD_INTERFACES x pspin_cmd_resp_t  completions.
- cluster_resp_valid_o  out  NUM_CLUSTERS  one-cycle completion strobe; no backpressure.
- cluster_resp_o  out  pspin_cmd_resp_t  completion, broadcast to all clusters.
- busy_o  out  1  high if the command register is full, a response is being delivered, or any credit counter is nonzero.
- err_o  out  1  sticky error flag; cleared only by reset.

Behaviour:
Reset:
- All outputs are 0.
- Credit counters are 0.
- Both round-robin pointers are 0.
- Command register is empty.
- Reset asserted mid-operation discards in-flight state immediately.

Command path:
- Single holding register, cmd_q, with a valid bit.
- Eligible cluster: valid_i is high AND credit < MAX_OUTSTANDING.
- Round-robin grant: search starts at cmd_ptr. After a grant, cmd_ptr = granted index + 1, modulo NUM_CLUSTERS.
- Grant happens when cmd_q is empty, or cmd_q drains in the same cycle (full throughput, 1 cmd/cycle).
- cluster_cmd_ready_o is one-hot on the granted cluster and zero otherwise.
- Ready is combinational from valid_i/credit/ptr/drain. A cluster must not make valid depend on ready.
- Latency: command accepted in cycle N → intf_cmd_valid_o[intf_id] high in cycle N+1.
- intf_cmd_o holds stable while valid and not ready. At most one intf_cmd_valid_o bit is high.
- intf_id >= NUM_CMD_INTERFACES: the command is accepted and dropped, err_o is set, no credit is consumed, and cmd_q stays empty.

Credits:
- Per-cluster counter, width $clog2(MAX_OUTSTANDING+1).
- Increment when a valid command is accepted from that cluster.
- Decrement when a response is delivered to that cluster.
- Increment and decrement in the same cycle: counter is unchanged.
- A cluster at MAX_OUTSTANDING receives no grant until a response frees a credit. That response frees the credit in the cycle after delivery (registered counter).
- Response addressed to a cluster whose counter is 0: delivered anyway, counter stays 0 (no underflow), err_o is set.

Response path:
- Round-robin over intf_resp_valid_i using resp_ptr, with the same pointer-update rule as the command path. One response accepted per cycle.
- intf_resp_ready_o is one-hot on the granted interface and always grantable (no backpressure from clusters).
- Accepted in cycle N → registered cluster_resp_o in cycle N+1, with cluster_resp_valid_o[cmd_id.cluster_id] high for exactly one cycle.
- cluster_id >= NUM_CLUSTERS: response dropped, err_o set.

Simultaneous events:
- Command and response paths are independent and may both transfer in the same cycle.

Test Plan:
- Single command: cluster 2 sends intf_id=1, cmd_id={2,5,3}, interface ready → intf_cmd_valid_o=3'b010 at N+1 with identical payload; credit[2]=1; response on intf 1 → cluster_resp_valid_o=4'b0100 one cycle later; credit[2]=0; busy_o falls.
- Fairness: all 4 clusters hold valid, all interfaces ready → grant order 0,1,2,3,0,… with 1 cmd/cycle and no bubbles.
- Backpressure: intf 2 ready low for 5 cycles → intf_cmd_o stable; no cluster ready while cmd_q is full; on release the next grant occurs in the same cycle as the drain.
- Credit limit: cluster 0 issues 32 commands with no responses → 33rd held (ready low); one response to cluster 0 → 33rd accepted 1 cycle after delivery.
- Errors: intf_id=3 → command dropped, err_o=1, credit unchanged. Separately, a response to a cluster with credit 0 → delivered, err_o=1.
- Reset mid-flight: rst_ni pulled low while cmd_q is full with credits at 4 → all outputs 0 asynchronously; after release, counters and pointers are 0.
